connect4_turn_ctrl: RTL and testbench

CONNECT4_TURN_CTRL -- requirements
Module: connect4_turn_ctrl

---
 rtl/connect4_turn_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_connect4_turn_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/connect4_turn_ctrl.sv
// Connect-4 turn controller: sequences player moves, board writes,
// result checks, per-turn timeouts and game restarts.
module connect4_turn_ctrl #(
    parameter int unsigned NUM_COLS     = 7,
    parameter int unsigned TURN_TIMEOUT = 50_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                p1_enter,
    input  logic [2:0]          p1_col,
    input  logic                p2_enter,
    input  logic [2:0]          p2_col,
    input  logic [NUM_COLS-1:0] col_full,
    input  logic                wr_ack,
    input  logic                res_valid,
    input  logic                win,
    input  logic                draw,
    input  logic                new_game,
    output logic                wr_en,
    output logic [2:0]          wr_col,
    output logic                wr_player,
    output logic [1:0]          leds,
    output logic                illegal,
    output logic                timeout,
    output logic                game_over,
    output logic [1:0]          winner
);

    localparam int unsigned CNT_W = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TURN_TIMEOUT - 1);
    localparam int unsigned PAD_W = 8;

    localparam logic [2:0] P1_TURN  = 3'd0;
    localparam logic [2:0] P1_WRITE = 3'd1;
    localparam logic [2:0] P1_CHECK = 3'd2;
    localparam logic [2:0] P2_TURN  = 3'd3;
    localparam logic [2:0] P2_WRITE = 3'd4;
    localparam logic [2:0] P2_CHECK = 3'd5;
    localparam logic [2:0] OVER     = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             starter_q, starter_d;
    logic [2:0]       col_d;
    logic [1:0]       winner_d, leds_d;
    logic             wr_en_d, wr_player_d, illegal_d, timeout_d, game_over_d;
    logic [PAD_W-1:0] full_pad;
    logic             p1_legal, p2_legal, expired;

    function automatic logic is_turn(input logic [2:0] s);
        return (s == P1_TURN) || (s == P2_TURN);
    endfunction

    // Move legality: column in range and not yet full
    assign full_pad = PAD_W'(col_full);
    assign p1_legal = (32'(p1_col) < NUM_COLS) && !full_pad[p1_col];
    assign p2_legal = (32'(p2_col) < NUM_COLS) && !full_pad[p2_col];
    assign expired  = (cnt_q == CNT_LAST);

    // Next-state, turn counter and next-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        starter_d = starter_q;
        col_d     = wr_col;
        winner_d  = winner;
        illegal_d = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            P1_TURN: begin
                if (p1_enter && p1_legal) begin
                    col_d   = p1_col;
                    state_d = P1_WRITE;
                end else begin
                    illegal_d = p1_enter;
                    if (expired) begin
                        timeout_d = 1'b1;
                        state_d   = P2_TURN;
                    end
                end
            end
            P2_TURN: begin
                if (p2_enter && p2_legal) begin
                    col_d   = p2_col;
                    state_d = P2_WRITE;
                end else begin
                    illegal_d = p2_enter;
                    if (expired) begin
                        timeout_d = 1'b1;
                        state_d   = P1_TURN;
                    end
                end
            end
            P1_WRITE: if (wr_ack) state_d = P1_CHECK;
            P2_WRITE: if (wr_ack) state_d = P2_CHECK;
            P1_CHECK: begin
                if (res_valid) begin
                    if (win) begin
                        winner_d = 2'b01;
                        state_d  = OVER;
                    end else if (draw) begin
                        winner_d = 2'b11;
                        state_d  = OVER;
                    end else begin
                        state_d  = P2_TURN;
                    end
                end
            end
            P2_CHECK: begin
                if (res_valid) begin
                    if (win) begin
                        winner_d = 2'b10;
                        state_d  = OVER;
                    end else if (draw) begin
                        winner_d = 2'b11;
                        state_d  = OVER;
                    end else begin
                        state_d  = P1_TURN;
                    end
                end
            end
            OVER: begin
                if (new_game) begin
                    winner_d  = 2'b00;
                    starter_d = ~starter_q;
                    state_d   = starter_q ? P1_TURN : P2_TURN;
                end
            end
            default: state_d = P1_TURN;
        endcase

        // Counter clears on TURN entry, counts while staying, freezes elsewhere
        if (is_turn(state_d) && (state_d != state_q)) begin
            cnt_d = '0;
        end else if (is_turn(state_q) && (state_d == state_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        wr_en_d     = (state_d == P1_WRITE) || (state_d == P2_WRITE);
        wr_player_d = (state_d == P2_WRITE);
        game_over_d = (state_d == OVER);
        if (state_d == OVER) begin
            leds_d = 2'b00;
        end else if ((state_d == P2_TURN) || (state_d == P2_WRITE) || (state_d == P2_CHECK)) begin
            leds_d = 2'b10;
        end else begin
            leds_d = 2'b01;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= P1_TURN;
            cnt_q     <= '0;
            starter_q <= 1'b0;
            wr_en     <= 1'b0;
            wr_col    <= 3'd0;
            wr_player <= 1'b0;
            leds      <= 2'b01;
            illegal   <= 1'b0;
            timeout   <= 1'b0;
            game_over <= 1'b0;
            winner    <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            starter_q <= starter_d;
            wr_en     <= wr_en_d;
            wr_col    <= col_d;
            wr_player <= wr_player_d;
            leds      <= leds_d;
            illegal   <= illegal_d;
            timeout   <= timeout_d;
            game_over <= game_over_d;
            winner    <= winner_d;
        end
    end

endmodule

// File: tb/tb_connect4_turn_ctrl.sv
// Testbench for connect4_turn_ctrl: vector table driven through a scoreboard,
// plus a hand-written asynchronous reset sequence.
module tb_connect4_turn_ctrl;

    typedef struct packed {
        logic       p1e;
        logic [2:0] p1c;
        logic       p2e;
        logic [2:0] p2c;
        logic [6:0] full;
        logic       ack;
        logic       rv;
        logic       wn;
        logic       dr;
        logic       ng;
    } in_t;

    typedef struct packed {
        logic       en;
        logic [2:0] col;
        logic       pl;
        logic [1:0] leds;
        logic       ill;
        logic       to;
        logic       go;
        logic [1:0] wnr;
    } out_t;

    typedef struct {
        in_t   i;
        out_t  o;
        string tag;
    } vec_t;

    typedef struct {
        out_t  o;
        string tag;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       p1_enter, p2_enter;
    logic [2:0] p1_col, p2_col;
    logic [6:0] col_full;
    logic       wr_ack, res_valid, win, draw, new_game;
    logic       wr_en, wr_player, illegal, timeout, game_over;
    logic [2:0] wr_col;
    logic [1:0] leds, winner;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];
    exp_t sb[$];
    out_t act;

    connect4_turn_ctrl #(.NUM_COLS(7), .TURN_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .p1_enter(p1_enter), .p1_col(p1_col),
        .p2_enter(p2_enter), .p2_col(p2_col),
        .col_full(col_full), .wr_ack(wr_ack),
        .res_valid(res_valid), .win(win), .draw(draw), .new_game(new_game),
        .wr_en(wr_en), .wr_col(wr_col), .wr_player(wr_player), .leds(leds),
        .illegal(illegal), .timeout(timeout), .game_over(game_over), .winner(winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb act = {wr_en, wr_col, wr_player, leds, illegal, timeout, game_over, winner};

    // Input builders
    function automatic in_t idle();
        return '0;
    endfunction
    function automatic in_t p1(input logic [2:0] c, input logic [6:0] f);
        in_t r = '0; r.p1e = 1'b1; r.p1c = c; r.full = f; return r;
    endfunction
    function automatic in_t p2(input logic [2:0] c, input logic [6:0] f);
        in_t r = '0; r.p2e = 1'b1; r.p2c = c; r.full = f; return r;
    endfunction
    function automatic in_t ack();
        in_t r = '0; r.ack = 1'b1; return r;
    endfunction
    function automatic in_t rv(input logic w, input logic d);
        in_t r = '0; r.rv = 1'b1; r.wn = w; r.dr = d; return r;
    endfunction
    function automatic in_t ng();
        in_t r = '0; r.ng = 1'b1; return r;
    endfunction

    // Expected-output builders
    function automatic out_t mk(input logic en, input logic [2:0] c, input logic pl,
                                input logic [1:0] l, input logic go, input logic [1:0] w);
        out_t r = '0;
        r.en = en; r.col = c; r.pl = pl; r.leds = l; r.go = go; r.wnr = w;
        return r;
    endfunction
    function automatic out_t tp1(input logic [2:0] c); return mk(1'b0, c, 1'b0, 2'b01, 1'b0, 2'b00); endfunction
    function automatic out_t wr1(input logic [2:0] c); return mk(1'b1, c, 1'b0, 2'b01, 1'b0, 2'b00); endfunction
    function automatic out_t tp2(input logic [2:0] c); return mk(1'b0, c, 1'b0, 2'b10, 1'b0, 2'b00); endfunction
    function automatic out_t wr2(input logic [2:0] c); return mk(1'b1, c, 1'b1, 2'b10, 1'b0, 2'b00); endfunction
    function automatic out_t ovr(input logic [2:0] c, input logic [1:0] w); return mk(1'b0, c, 1'b0, 2'b00, 1'b1, w); endfunction
    function automatic out_t pulse(input out_t x, input logic ill, input logic to);
        out_t r = x; r.ill = ill; r.to = to; return r;
    endfunction

    function automatic string fmt(input out_t x);
        return $sformatf("en=%b col=%0d pl=%b leds=%b ill=%b to=%b go=%b winner=%b",
                         x.en, x.col, x.pl, x.leds, x.ill, x.to, x.go, x.wnr);
    endfunction

    function void add(input in_t i, input out_t o, input string tag);
        vec_t v;
        v.i = i; v.o = o; v.tag = tag;
        tbl.push_back(v);
    endfunction

    task automatic compare(input string tag, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got {%s} expected {%s}", tag, fmt(act), fmt(exp));
        end
    endtask

    task automatic apply(input in_t i);
        p1_enter = i.p1e; p1_col = i.p1c; p2_enter = i.p2e; p2_col = i.p2c;
        col_full = i.full; wr_ack = i.ack; res_valid = i.rv; win = i.wn;
        draw = i.dr; new_game = i.ng;
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge
    task automatic drive(input in_t i, input out_t o, input string tag);
        exp_t e;
        @(negedge clk);
        apply(i);
        e.o = o; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain scoreboard still holds %0d entries, required 0", sb.size());
            sb.delete();
        end
    endtask

    // Scoreboard checker: outputs settle just after each active edge
    always begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            compare(e.tag, e.o);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Vector table: each row is one cycle; expected outputs follow that cycle's edge
        add(p1(3'd3, 7'd0), wr1(3'd3), "p1_col3_write");
        add(idle(),         wr1(3'd3), "p1_wait_ack");
        add(ack(),          tp1(3'd3), "p1_check");
        add(rv(1'b0, 1'b0), tp2(3'd3), "pass_to_p2");
        add(p2(3'd0, 7'd0), wr2(3'd0), "p2_col0_write");
        add(ack(),          tp2(3'd0), "p2_check");
        add(rv(1'b0, 1'b0), tp1(3'd0), "pass_to_p1");
        add(p1(3'd5, 7'b0100000), pulse(tp1(3'd0), 1'b1, 1'b0), "illegal_full_col");
        add(idle(),         tp1(3'd0), "illegal_one_cycle");
        add(p1(3'd7, 7'd0), pulse(tp1(3'd0), 1'b1, 1'b0), "illegal_col7");
        add(p2(3'd2, 7'd0), tp1(3'd0), "p2_enter_ignored");
        add(ng(),           tp1(3'd0), "new_game_ignored");
        add(p1(3'd1, 7'd0), wr1(3'd1), "p1_col1_write");
        add(ack(),          tp1(3'd1), "p1_check2");
        add(rv(1'b0, 1'b0), tp2(3'd1), "pass_to_p2_b");
        for (int k = 0; k < 7; k++) add(idle(), tp2(3'd1), "p2_idle");
        add(idle(),         pulse(tp1(3'd1), 1'b0, 1'b1), "timeout_p2");
        add(idle(),         tp1(3'd1), "timeout_once");
        for (int k = 0; k < 6; k++) add(idle(), tp1(3'd1), "p1_idle");
        add(p1(3'd6, 7'd0), wr1(3'd6), "legal_at_expiry");
        add(ack(),          tp1(3'd6), "p1_check3");
        add(rv(1'b0, 1'b0), tp2(3'd6), "pass_to_p2_c");
        for (int k = 0; k < 7; k++) add(idle(), tp2(3'd6), "p2_idle_b");
        add(p2(3'd7, 7'd0), pulse(tp1(3'd6), 1'b1, 1'b1), "illegal_at_expiry");
        add(p1(3'd2, 7'd0), wr1(3'd2), "p1_col2_write");
        add(ack(),          tp1(3'd2), "p1_check4");
        add(rv(1'b0, 1'b0), tp2(3'd2), "pass_to_p2_d");
        add(p2(3'd4, 7'd0), wr2(3'd4), "p2_col4_write");
        add(ack(),          tp2(3'd4), "p2_check2");
        add(rv(1'b1, 1'b1), ovr(3'd4, 2'b10), "p2_win_over_draw");
        add(in_t'(p1(3'd0, 7'd0) | p2(3'd1, 7'd0)), ovr(3'd4, 2'b10), "enters_ignored_over");
        add(in_t'(ack() | rv(1'b1, 1'b0)), ovr(3'd4, 2'b10), "results_ignored_over");
        add(ng(),           tp2(3'd4), "new_game_p2_starts");
        add(p2(3'd3, 7'd0), wr2(3'd3), "p2_col3_write");
        add(ack(),          tp2(3'd3), "p2_check3");
        add(rv(1'b0, 1'b1), ovr(3'd3, 2'b11), "draw_over");
        add(ng(),           tp1(3'd3), "new_game_p1_starts");

        reset = 1'b0;
        apply(idle());
        repeat (3) @(posedge clk);
        #1;
        compare("reset_state", tp1(3'd0));
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[k]) drive(tbl[k].i, tbl[k].o, tbl[k].tag);
        drain();

        // Stall in P1_WRITE without ack, then reset asynchronously mid-write
        drive(p1(3'd3, 7'd0), wr1(3'd3), "stall_write");
        for (int k = 0; k < 20; k++) drive(idle(), wr1(3'd3), "stall_no_ack");
        drain();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        compare("async_reset_drop", tp1(3'd0));
        @(posedge clk);
        #1;
        compare("reset_held", tp1(3'd0));
        @(negedge clk);
        reset = 1'b1;
        drive(idle(),         tp1(3'd0), "after_reset_p1_turn");
        drive(p1(3'd4, 7'd0), wr1(3'd4), "after_reset_write");
        drive(idle(),         wr1(3'd4), "after_reset_hold");
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
